// File: rtl/weight_fetch_ctrl.sv
// Weight fetch controller: streams consecutive ROM words, packs WORDS_PER_GROUP
// of them into one wide weight group and hands each group out on valid/ready.
module weight_fetch_ctrl #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_GROUP = 2,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [ADDR_WIDTH-1:0]                 base_addr,
    input  logic [CNT_WIDTH-1:0]                  num_groups,
    output logic                                  busy,
    output logic                                  done,
    output logic                                  rom_en,
    output logic [ADDR_WIDTH-1:0]                 rom_addr,
    input  logic [DATA_WIDTH-1:0]                 rom_data,
    output logic                                  w_valid,
    input  logic                                  w_ready,
    output logic [WORDS_PER_GROUP*DATA_WIDTH-1:0] w_data,
    output logic                                  w_last
);

    localparam int WC_W = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1;

    localparam logic [WC_W-1:0]       LAST_WORD = WC_W'(WORDS_PER_GROUP - 1);
    localparam logic [WC_W-1:0]       WC_ZERO   = {WC_W{1'b0}};
    localparam logic [WC_W-1:0]       WC_ONE    = WC_W'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ZERO  = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                                state_r;
    state_t                                state_nxt_s;
    logic [ADDR_WIDTH-1:0]                 next_addr_r;
    logic [ADDR_WIDTH-1:0]                 fetch_addr_s;
    logic [WC_W-1:0]                       word_cnt_r;
    logic [WC_W-1:0]                       cap_idx_r;
    logic [CNT_WIDTH-1:0]                  rem_r;
    logic [CNT_WIDTH-1:0]                  rem_nxt_s;
    logic                                  rd_pend_r;
    logic                                  accept_s;
    logic                                  zero_req_s;
    logic                                  handshake_s;
    logic                                  busy_r;
    logic                                  done_r;
    logic                                  rom_en_r;
    logic [ADDR_WIDTH-1:0]                 rom_addr_r;
    logic                                  w_valid_r;
    logic                                  w_last_r;
    logic [WORDS_PER_GROUP*DATA_WIDTH-1:0] w_data_r;
    logic                                  busy_nxt_s;
    logic                                  done_nxt_s;
    logic                                  rom_en_nxt_s;
    logic                                  w_valid_nxt_s;
    logic                                  w_last_nxt_s;

    function automatic logic [WC_W-1:0] slot_after(input logic [WC_W-1:0] idx);
        if (idx == LAST_WORD) begin
            return WC_ZERO;
        end else begin
            return idx + WC_ONE;
        end
    endfunction

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        zero_req_s  = 1'b0;
        handshake_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (num_groups != CNT_ZERO) begin
                        accept_s    = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        zero_req_s  = 1'b1;
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                if (word_cnt_r == LAST_WORD) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ISSUE;
                end
            end
            DRAIN: begin
                state_nxt_s = HOLD;
            end
            HOLD: begin
                if (w_ready) begin
                    handshake_s = 1'b1;
                    if (rem_r == CNT_ONE) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = ISSUE;
                    end
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Output decode: values the output registers take on the coming edge
    always_comb begin
        rem_nxt_s    = rem_r;
        fetch_addr_s = next_addr_r;
        if (accept_s) begin
            rem_nxt_s = num_groups;
        end else if (handshake_s) begin
            rem_nxt_s = rem_r - CNT_ONE;
        end else begin
            rem_nxt_s = rem_r;
        end
        if (state_r == IDLE) begin
            fetch_addr_s = base_addr;
        end else begin
            fetch_addr_s = next_addr_r;
        end
        busy_nxt_s    = (state_nxt_s != IDLE);
        rom_en_nxt_s  = (state_nxt_s == ISSUE);
        w_valid_nxt_s = (state_nxt_s == HOLD);
        w_last_nxt_s  = (state_nxt_s == HOLD) && (rem_nxt_s == CNT_ONE);
        done_nxt_s    = zero_req_s || (handshake_s && (rem_r == CNT_ONE));
    end

    // State, counters, address and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            rem_r       <= CNT_ZERO;
            word_cnt_r  <= WC_ZERO;
            next_addr_r <= ADDR_ZERO;
            rom_addr_r  <= ADDR_ZERO;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            rom_en_r    <= 1'b0;
            w_valid_r   <= 1'b0;
            w_last_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            rem_r     <= rem_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            rom_en_r  <= rom_en_nxt_s;
            w_valid_r <= w_valid_nxt_s;
            w_last_r  <= w_last_nxt_s;
            // rom_addr only moves when a read is actually presented
            if (state_nxt_s == ISSUE) begin
                rom_addr_r  <= fetch_addr_s;
                next_addr_r <= fetch_addr_s + ADDR_ONE;
                if (state_r == ISSUE) begin
                    word_cnt_r <= word_cnt_r + WC_ONE;
                end else begin
                    word_cnt_r <= WC_ZERO;
                end
            end else begin
                rom_addr_r  <= rom_addr_r;
                next_addr_r <= next_addr_r;
                word_cnt_r  <= word_cnt_r;
            end
        end
    end

    // Word capture one cycle behind each read; reset drops any read in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend_r <= 1'b0;
            cap_idx_r <= WC_ZERO;
            w_data_r  <= {(WORDS_PER_GROUP*DATA_WIDTH){1'b0}};
        end else begin
            rd_pend_r <= rom_en_r;
            if (rd_pend_r) begin
                for (int k = 0; k < WORDS_PER_GROUP; k++) begin
                    if (cap_idx_r == WC_W'(k)) begin
                        w_data_r[k*DATA_WIDTH +: DATA_WIDTH] <= rom_data;
                    end
                end
                cap_idx_r <= slot_after(cap_idx_r);
            end else begin
                cap_idx_r <= cap_idx_r;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rom_en   = rom_en_r;
    assign rom_addr = rom_addr_r;
    assign w_valid  = w_valid_r;
    assign w_last   = w_last_r;
    assign w_data   = w_data_r;

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Scoreboard bench for weight_fetch_ctrl: ROM addresses and weight groups are
// predicted at request time and compared as the controller produces them.
module tb_weight_fetch_ctrl;

    localparam int AW  = 8;
    localparam int DW  = 32;
    localparam int WPG = 2;
    localparam int CW  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [AW-1:0]     base_addr;
    logic [CW-1:0]     num_groups;
    logic              busy;
    logic              done;
    logic              rom_en;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_data;
    logic              w_valid;
    logic              w_ready;
    logic [WPG*DW-1:0] w_data;
    logic              w_last;

    int n_cmp = 0;
    int n_mis = 0;
    int hs_cnt = 0;

    logic [AW-1:0]     addr_q[$];
    logic [WPG*DW:0]   grp_q[$];
    logic [AW-1:0]     ea;
    logic [WPG*DW:0]   eg;
    logic [WPG*DW-1:0] held;
    logic [4:0]        exp5;

    weight_fetch_ctrl #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WORDS_PER_GROUP(WPG), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_groups(num_groups), .busy(busy), .done(done), .rom_en(rom_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .w_valid(w_valid),
        .w_ready(w_ready), .w_data(w_data), .w_last(w_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
        return 32'h0000_A000 + {24'h0, a};
    endfunction

    // Synchronous-read ROM model
    always @(posedge clk) begin
        if (rom_en) rom_data <= rom_word(rom_addr);
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_req(input logic [AW-1:0] base, input logic [CW-1:0] n);
        logic [AW-1:0]     a;
        logic [WPG*DW-1:0] g;
        a = base;
        for (int i = 0; i < int'(n); i++) begin
            for (int k = 0; k < WPG; k++) begin
                addr_q.push_back(a);
                g[k*DW +: DW] = rom_word(a);
                a = a + 8'd1;
            end
            grp_q.push_back({(i == int'(n) - 1), g});
        end
        base_addr  = base;
        num_groups = n;
        start      = 1'b1;
        step();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done) break;
            step();
        end
        chk_eq("done_seen", 64'(done), 64'd1);
    endtask

    task automatic chk_drained(input string tag);
        chk_eq({tag, "_addr_q"}, 64'(addr_q.size()), 64'd0);
        chk_eq({tag, "_grp_q"}, 64'(grp_q.size()), 64'd0);
    endtask

    // Monitor: ROM reads and group handshakes against the scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (rom_en) begin
                if (addr_q.size() == 0) begin
                    chk_eq("rom_unexpected", 64'd1, 64'd0);
                end else begin
                    ea = addr_q.pop_front();
                    chk_eq("rom_addr", 64'(rom_addr), 64'(ea));
                end
            end
            if (w_valid && w_ready) begin
                hs_cnt++;
                if (grp_q.size() == 0) begin
                    chk_eq("grp_unexpected", 64'd1, 64'd0);
                end else begin
                    eg = grp_q.pop_front();
                    chk_eq("w_data", w_data, eg[WPG*DW-1:0]);
                    chk_eq("w_last", 64'(w_last), 64'(eg[WPG*DW]));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 8'h00; num_groups = 8'h00; w_ready = 1'b0;
        step(); step();
        chk_eq("reset_ctrl", 64'({busy, done, rom_en, w_valid, w_last}), 64'd0);
        chk_eq("reset_addr", 64'(rom_addr), 64'd0);
        chk_eq("reset_data", w_data, 64'd0);
        rst = 1'b0;
        step();

        // Basic stream: cycle-exact timing of every control output
        w_ready = 1'b1;
        issue_req(8'h10, 8'd3);
        for (int t = 1; t <= 14; t++) begin
            exp5 = {(t >= 1 && t <= 12),
                    (t <= 12 && (t % 4 == 1 || t % 4 == 2)),
                    (t % 4 == 0 && t >= 4 && t <= 12),
                    (t == 12),
                    (t == 13)};
            chk_eq($sformatf("basic_t%0d", t),
                   64'({busy, rom_en, w_valid, w_last, done}), 64'(exp5));
            step();
        end
        chk_drained("basic");

        // Backpressure in the first HOLD
        w_ready = 1'b0;
        issue_req(8'h10, 8'd3);
        step(); step(); step();
        chk_eq("bp_first_valid", 64'(w_valid), 64'd1);
        held = w_data;
        chk_eq("bp_first_group", held, 64'h0000A011_0000A010);
        for (int i = 0; i < 5; i++) begin
            chk_eq("bp_valid_hold", 64'(w_valid), 64'd1);
            chk_eq("bp_data_stable", w_data, held);
            chk_eq("bp_rom_idle", 64'(rom_en), 64'd0);
            step();
        end
        w_ready = 1'b1;
        step();
        chk_eq("bp_next_read", 64'({rom_en, w_valid}), 64'b10);
        chk_eq("bp_next_addr", 64'(rom_addr), 64'h12);
        wait_done(40);
        chk_drained("bp");

        // Start while busy, first request issued in the done cycle
        hs_cnt = 0;
        w_ready = 1'b0;
        issue_req(8'h20, 8'd2);
        chk_eq("sb_accepted", 64'(busy), 64'd1);
        base_addr = 8'h80; num_groups = 8'd2; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        chk_eq("sb_hold_valid", 64'(w_valid), 64'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        w_ready = 1'b1;
        wait_done(40);
        step();
        chk_eq("sb_group_count", 64'(hs_cnt), 64'd2);
        chk_drained("sb");

        // Zero groups
        issue_req(8'h40, 8'd0);
        chk_eq("zero_t1", 64'({busy, rom_en, w_valid, done}), 64'b0001);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_eq("zero_quiet", 64'({busy, rom_en, w_valid, done}), 64'd0);
        end

        // Address wrap
        issue_req(8'hFF, 8'd1);
        wait_done(20);
        chk_eq("wrap_addr_held", 64'(rom_addr), 64'h00);
        chk_eq("wrap_group", w_data, 64'h0000A000_0000A0FF);
        chk_drained("wrap");

        // Reset during ISSUE, then a fresh request
        issue_req(8'h30, 8'd2);
        step();
        rst = 1'b1;
        addr_q.delete();
        grp_q.delete();
        step();
        chk_eq("rst_mid_ctrl", 64'({busy, done, rom_en, w_valid, w_last}), 64'd0);
        chk_eq("rst_mid_addr", 64'(rom_addr), 64'd0);
        chk_eq("rst_mid_data", w_data, 64'd0);
        rst = 1'b0;
        issue_req(8'h00, 8'd1);
        step(); step();
        chk_eq("rst_t3_valid", 64'(w_valid), 64'd0);
        step();
        chk_eq("rst_t4_valid", 64'({w_valid, w_last}), 64'b11);
        chk_eq("rst_group", w_data, 64'h0000A001_0000A000);
        wait_done(20);
        step();
        chk_drained("rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/weight_fetch_ctrl.md
# weight_fetch_ctrl

Controller that streams binary conv weights from a per-block weight ROM (synchronous read, 1-cycle latency, `enable`/`addr`/`data_o` interface) to the PE array. On a `start` pulse it reads `num_groups × WORDS_PER_GROUP` consecutive ROM words beginning at `base_addr`. It packs every `WORDS_PER_GROUP` words into one wide weight group and presents each group on a valid/ready port. It sits directly downstream of the weight ROMs, upstream of the XNOR-popcount PE array, and is driven by the layer sequencer.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, ROM address width
- `DATA_WIDTH`, 32, ROM word width
- `WORDS_PER_GROUP`, 2, ROM words per weight group (≥1)
- `CNT_WIDTH`, 8, width of group counter

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first ROM address; sampled with `start`
- `num_groups`  in  CNT_WIDTH  groups to fetch; sampled with `start`
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at end of request
- `rom_en`  out  1  ROM read enable
- `rom_addr`  out  ADDR_WIDTH  ROM read address
- `rom_data`  in  DATA_WIDTH  ROM read data; valid one cycle after `rom_en`
- `w_valid`  out  1  weight group valid
- `w_ready`  in  1  PE array accepts group
- `w_data`  out  WORDS_PER_GROUP×DATA_WIDTH  group; word k at bits [k·DATA_WIDTH +: DATA_WIDTH]
- `w_last`  out  1  high with `w_valid` on the final group

## Operation
- **Reset values:** all outputs 0; state IDLE; counters 0.
- **State IDLE**
  - If `start` and `num_groups` ≠ 0: latch `base_addr` into the address register and `num_groups` into the remaining counter, then go to ISSUE.
  - If `start` and `num_groups` = 0: stay in IDLE and pulse `done` the next cycle. `busy` stays low and no ROM read is issued.
- **State ISSUE:** one read per cycle (`rom_en`=1, `rom_addr`=current address). The address increments modulo 2^ADDR_WIDTH. After the WORDS_PER_GROUP-th read, go to DRAIN.
- **State DRAIN:** one cycle that captures the last word; the next state is HOLD with `w_valid`=1.
- **Word capture:** each ROM word is captured into slot k of the group register in the cycle after its read. k counts 0..WORDS_PER_GROUP-1 in read order.
- **State HOLD:** `w_valid`=1. `w_data` and `w_last` are stable and `rom_en`=0. On `w_valid && w_ready`, decrement the remaining counter:
  - remaining > 0: go to ISSUE (next group).
  - remaining = 0: go to IDLE and pulse `done`.
- `w_valid` is never asserted outside HOLD. `w_last` = (remaining == 1) while in HOLD, else 0.
- `start` is ignored while `busy`.
- When `rom_en`=0, `rom_addr` holds its last value.
- **Reset mid-operation:** all outputs and state return to reset values on the next edge, and any ROM data in flight is discarded.

## Timing
- `start` accepted at cycle T0:
  - `busy` high from T1.
  - First read at T1; reads at T1..T(WORDS_PER_GROUP).
  - First `w_valid` at T(WORDS_PER_GROUP+2), which is T4 for the default.
- Handshake at cycle H:
  - `w_valid` low at H+1.
  - Next group's reads start at H+1; its `w_valid` rises at H+WORDS_PER_GROUP+2.
  - Throughput with `w_ready` held high: one group per WORDS_PER_GROUP+2 cycles.
- Final handshake at H: `done`=1 and `busy`=0 at H+1; `done` is low again at H+2.
- A new `start` is accepted at H+1, in the same cycle `done` is high.

## Test plan
- **Basic stream:** ROM model returns addr+0xA000 (32-bit), `base_addr`=0x10, `num_groups`=3, `w_ready`=1.
  - Reads 0x10..0x15.
  - Groups {0xA011,0xA010}, {0xA013,0xA012}, {0xA015,0xA014}, with word 0 in the low 32 bits.
  - `w_valid` at T4, T8, T12; `w_last` only at T12; `done` at T13.
- **Backpressure:** same request with `w_ready` low for 5 cycles during the first HOLD.
  - `w_data` stable and `rom_en`=0 throughout.
  - Second group's reads begin the cycle after `w_ready` rises.
- **Zero groups:** `start` with `num_groups`=0 → `done`=1 at T1; `busy`, `rom_en` and `w_valid` never high.
- **Address wrap:** `base_addr`=0xFF, `num_groups`=1 → reads at 0xFF then 0x00; group {mem[0x00], mem[0xFF]}.
- **Start while busy:** `start` with `num_groups`=2 pulsed in ISSUE and again in HOLD → both ignored; exactly 2 groups are delivered.
- **Reset mid-ISSUE:** `rst` during ISSUE → all outputs 0 next cycle; a following `start` (`base_addr`=0x00, `num_groups`=1) delivers {mem[0x01], mem[0x00]} with normal timing.
